// File: rtl/axi_pkg.sv
// Shared AXI3 types for the slave memory, its interface and the protocol checker.
package axi_pkg;

  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3} burst_type_t;
  typedef enum logic [1:0] {NORMAL = 2'd0, EXCLUSIVE = 2'd1, LOCKED = 2'd2} lock_t;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;

  // Whole-burst SLVERR conditions known at address-phase time.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [3:0] len, input int max_size);
    logic bad_wrap;
    bad_wrap = (burst == WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
    return (burst == RSVD) || (int'(size) > max_size) || bad_wrap;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [3:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;

  always_comb begin
    bytes   = ADDR_WIDTH'(1) << size;
    span    = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    aligned = addr & ~(bytes - ADDR_WIDTH'(1));
    incr    = aligned + bytes;
    case (burst)
      FIXED:   next = addr;
      // span is a power of two for every legal WRAP length
      WRAP:    next = (addr & ~(span - ADDR_WIDTH'(1))) | (incr & (span - ADDR_WIDTH'(1)));
      default: next = incr;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave backed by a byte-addressed memory; independent write and read FSMs.
//  state  | meaning
//  W_IDLE | awready high, waiting for a write address
//  W_DATA | wready high, accepting write beats
//  W_RESP | bvalid high, holding bid/bresp until bready
//  R_IDLE | arready high, waiting for a read address
//  R_DATA | rvalid high, presenting the current read beat
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_BYTES  = 1024
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic [1:0]              awlock,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic [1:0]              arlock,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int NBW = $clog2(NB);
  localparam int MW  = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [7:0] mem [MEM_BYTES];

  logic unused_sideband;
  assign unused_sideband = ^{awcache, awprot, awlock, arcache, arprot, arlock};

  // ---------------- write path ----------------
  wstate_t               w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr, wa_next;
  logic [3:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [ID_WIDTH-1:0]   w_id;
  logic                  w_slv, w_dec;
  logic                  aw_hs, w_hs, b_hs;
  logic                  w_cnt_end, w_beat_last, w_beat_dec, w_beat_slv, mem_we;
  logic [MW-1:0]         w_base;

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next(wa_next)
  );

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bvalid & bready;
  assign w_cnt_end   = (w_cnt == w_len);
  assign w_beat_last = wlast | w_cnt_end;
  assign w_beat_dec  = (w_addr >= ADDR_WIDTH'(MEM_BYTES));
  assign w_beat_slv  = w_slv | (wid != w_id) | (wlast != w_cnt_end);
  assign mem_we      = w_hs & ~w_beat_slv & ~w_beat_dec;
  assign w_base      = w_addr[MW-1:0] & ~MW'(NB - 1);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_beat_last) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they read 0 in reset.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_id    <= '0;
      w_cnt   <= '0;
      w_slv   <= 1'b0;
      w_dec   <= 1'b0;
    end else begin
      w_state <= w_next;
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_id    <= awid;
        w_cnt   <= '0;
        w_slv   <= burst_err(awburst, awsize, awlen, NBW);
        w_dec   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= wa_next;
        w_cnt  <= w_cnt + 4'd1;
        w_slv  <= w_beat_slv;
        w_dec  <= w_dec | w_beat_dec;
        if (w_beat_last) begin
          bid   <= w_id;
          bresp <= w_beat_slv ? SLVERR : ((w_dec | w_beat_dec) ? DECERR : OKAY);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[w_base + MW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t               r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, ra_next, rd_addr;
  logic [3:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_slv;
  logic                  ar_hs, r_hs, r_cnt_end, r_load, rd_slv, rd_dec;
  logic [MW-1:0]         rd_base;
  logic [DATA_WIDTH-1:0] rd_word;

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next(ra_next)
  );

  assign ar_hs     = arvalid & arready;
  assign r_hs      = rvalid & rready;
  assign r_cnt_end = (r_cnt == r_len);
  assign r_load    = ar_hs | (r_hs & ~r_cnt_end);
  // Address of the beat about to be loaded into the rdata register.
  assign rd_addr   = (r_state == R_IDLE) ? araddr : ra_next;
  assign rd_slv    = (r_state == R_IDLE) ? burst_err(arburst, arsize, arlen, NBW) : r_slv;
  assign rd_dec    = (rd_addr >= ADDR_WIDTH'(MEM_BYTES));
  assign rd_base   = rd_addr[MW-1:0] & ~MW'(NB - 1);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) rd_word[8*i +: 8] = mem[rd_base + MW'(i)];
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_cnt_end) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rid     <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_slv   <= 1'b0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= '0;
        r_slv   <= rd_slv;
        rid     <= arid;
        rlast   <= (arlen == 4'd0);
      end else if (r_hs && !r_cnt_end) begin
        r_addr <= ra_next;
        r_cnt  <= r_cnt + 4'd1;
        rlast  <= ((r_cnt + 4'd1) == r_len);
      end
      if (r_load) begin
        rdata <= (rd_slv | rd_dec) ? '0 : rd_word;
        rresp <= rd_slv ? SLVERR : (rd_dec ? DECERR : OKAY);
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: spec-level burst model plus per-cycle B/R monitor.
module tb_axi_slave_mem;
  import axi_pkg::*;

  localparam int AW = 32, DW = 32, IW = 4, MB = 1024;

  logic aclk = 1'b0, arstn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [3:0] awlen = '0, arlen = '0, awcache = '0, arcache = '0;
  logic [2:0] awsize = '0, arsize = '0, awprot = '0, arprot = '0;
  logic [1:0] awburst = '0, arburst = '0, awlock = '0, arlock = '0;
  logic [IW-1:0] awid = '0, arid = '0, wid = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [IW-1:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;

  axi_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_BYTES(MB)) dut (
    .aclk(aclk), .arstn(arstn),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awcache(awcache),
    .awprot(awprot), .awlock(awlock), .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arcache(arcache),
    .arprot(arprot), .arlock(arlock), .arid(arid), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_bad = 0;

  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} bexp_t;
  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rexp_t;
  bexp_t bq[$];
  rexp_t rq[$];

  logic [7:0]  mdl_mem [MB];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_cap [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Spec-level beat address: offset arithmetic rather than step-by-step recurrence.
  function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int n);
    longint a, bytes, span, al, base;
    a = longint'(a0);
    bytes = longint'(1) << size;
    span = (longint'(len) + 1) * bytes;
    if (n == 0 || burst == 2'd0) return a0;
    al = (a / bytes) * bytes;
    if (burst == 2'd2) begin
      base = (a / span) * span;
      return 32'(base + ((al - base + longint'(n) * bytes) % span));
    end
    return 32'(al + longint'(n) * bytes);
  endfunction

  function automatic bit burst_bad(input logic [1:0] burst, input logic [2:0] size, input logic [3:0] len);
    return burst == 2'd3 || size > 3'd2 ||
           (burst == 2'd2 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
  endfunction

  function automatic logic sel(input int w);
    case (w)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string name);
    int t = 0;
    forever begin
      @(negedge aclk);
      if (sel(w)) break;
      t++;
      if (t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout_%s: got no handshake, expected one within 200 cycles", name);
        break;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [3:0] wid_v,
                          input int nsent, input int bstall);
    int wl, e;
    bit slv, dec, bs, ad;
    logic [31:0] ba;
    wl = nsent - 1;
    e = (wl < int'(len)) ? wl : int'(len);
    slv = burst_bad(burst, size, len);
    dec = 0;
    for (int n = 0; n <= e; n++) begin
      ba = beat_addr(a, len, size, burst, n);
      ad = (ba >= MB);
      bs = slv || (wid_v != id) || ((n == wl) != (n == int'(len)));
      if (!bs && !ad)
        for (int i = 0; i < 4; i++) if (ws[n][i]) mdl_mem[(ba & ~32'd3) + i] = wd[n][8*i +: 8];
      slv = bs;
      dec = dec || ad;
    end
    bq.push_back('{id, slv ? 2'd2 : (dec ? 2'd3 : 2'd0)});
    @(posedge aclk); #1;
    awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    wait_sig(0, "awready");
    @(posedge aclk); #1 awvalid = 1'b0;
    for (int n = 0; n <= e; n++) begin
      wvalid = 1'b1; wdata = wd[n]; wstrb = ws[n]; wlast = (n == wl); wid = wid_v;
      wait_sig(1, "wready");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    wait_sig(2, "bvalid");
    repeat (bstall) @(negedge aclk);
    @(posedge aclk); #1 bready = 1'b1;
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id,
                         input int stall_beat, input int stall_n, input int abort_at);
    logic [31:0] ba, b, d;
    bit bad, ad;
    bad = burst_bad(burst, size, len);
    for (int n = 0; n <= int'(len); n++) begin
      ba = beat_addr(a, len, size, burst, n);
      ad = (ba >= MB);
      b = ba & ~32'd3;
      d = (bad || ad) ? 32'd0 : {mdl_mem[b+3], mdl_mem[b+2], mdl_mem[b+1], mdl_mem[b]};
      rq.push_back('{id, d, bad ? 2'd2 : (ad ? 2'd3 : 2'd0), n == int'(len)});
    end
    @(posedge aclk); #1;
    araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    wait_sig(3, "arready");
    @(posedge aclk); #1 arvalid = 1'b0;
    for (int n = 0; n <= int'(len); n++) begin
      wait_sig(4, "rvalid");
      if (n == abort_at) return;
      if (n == stall_beat) repeat (stall_n) @(negedge aclk);
      rd_cap[n] = rdata;
      @(posedge aclk); #1 rready = 1'b1;
      @(posedge aclk); #1 rready = 1'b0;
    end
  endtask

  // Per-cycle compare of B and R against the model queues, plus hold-until-accepted.
  logic pb_v = 0, pb_r = 0, pr_v = 0, pr_r = 0;
  logic [IW+1:0] pb_pay;
  logic [IW+DW+2:0] pr_pay;
  always @(negedge aclk) begin
    if (!arstn) begin
      pb_v = 0; pr_v = 0;
    end else begin
      if (pb_v && !pb_r) chk("b_hold", {bvalid, bid, bresp}, {1'b1, pb_pay});
      if (bvalid) begin
        if (bq.size() == 0) chk("b_unexpected_valid", bvalid, 0);
        else begin
          chk("b_payload", {bid, bresp}, {bq[0].id, bq[0].resp});
          if (bready) void'(bq.pop_front());
        end
      end
      pb_v = bvalid; pb_r = bready; pb_pay = {bid, bresp};
      if (pr_v && !pr_r) chk("r_hold", {rvalid, rid, rdata, rresp, rlast}, {1'b1, pr_pay});
      if (rvalid) begin
        if (rq.size() == 0) chk("r_unexpected_valid", rvalid, 0);
        else begin
          chk("r_payload", {rid, rdata, rresp, rlast}, {rq[0].id, rq[0].data, rq[0].resp, rq[0].last});
          if (rready) void'(rq.pop_front());
        end
      end
      pr_v = rvalid; pr_r = rready; pr_pay = {rid, rdata, rresp, rlast};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MB; i++) mdl_mem[i] = 8'h00;
    repeat (3) @(posedge aclk); #1;
    chk("reset_outputs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rdata, rid, rresp, rlast}, 64'd0);
    arstn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    chk("post_reset_ready", {awready, wready, arready}, 3'b101);

    // INCR write then read back
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(32'h10, 4'd3, 3'd2, INCR, 4'd5, 4'd5, 4, 0);
    do_read(32'h10, 4'd3, 3'd2, INCR, 4'd6, -1, 0, -1);
    chk("incr_beat0", rd_cap[0], 32'hA0);
    chk("incr_beat3", rd_cap[3], 32'hA3);

    // WRAP read, memory holds each word's own address
    wd[0] = 32'h30; wd[1] = 32'h34; wd[2] = 32'h38; wd[3] = 32'h3C;
    do_write(32'h30, 4'd3, 3'd2, INCR, 4'd1, 4'd1, 4, 0);
    do_read(32'h38, 4'd3, 3'd2, WRAP, 4'd7, -1, 0, -1);
    chk("wrap_beat0", rd_cap[0], 32'h38);
    chk("wrap_beat1", rd_cap[1], 32'h3C);
    chk("wrap_beat2", rd_cap[2], 32'h30);
    chk("wrap_beat3", rd_cap[3], 32'h34);

    // Byte strobes
    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(32'h0, 4'd0, 3'd2, INCR, 4'd2, 4'd2, 1, 0);
    wd[0] = 32'h11223344; ws[0] = 4'h5;
    do_write(32'h0, 4'd0, 3'd2, INCR, 4'd2, 4'd2, 1, 0);
    ws[0] = 4'hF;
    do_read(32'h0, 4'd0, 3'd2, INCR, 4'd3, -1, 0, -1);
    chk("strobe_word", rd_cap[0], 32'h00220044);

    // Backpressure on B and R
    wd[0] = 32'h1; wd[1] = 32'h2;
    do_write(32'h20, 4'd1, 3'd2, INCR, 4'd3, 4'd3, 2, 5);
    do_read(32'h20, 4'd1, 3'd2, INCR, 4'd4, 1, 5, -1);
    chk("stall_beat1", rd_cap[1], 32'h2);

    // FIXED: every beat hits the same word
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
    do_write(32'h50, 4'd2, 3'd2, FIXED, 4'd8, 4'd8, 3, 0);
    do_read(32'h50, 4'd0, 3'd2, INCR, 4'd8, -1, 0, -1);
    chk("fixed_final", rd_cap[0], 32'h33);

    // Error responses
    wd[0] = 32'hDEADBEEF;
    do_write(MB, 4'd0, 3'd2, INCR, 4'd1, 4'd1, 1, 0);
    do_read(32'h0, 4'd0, 3'd2, INCR, 4'd1, -1, 0, -1);
    chk("decerr_no_alias", rd_cap[0], 32'h00220044);
    wd[0] = 32'hCAFEF00D;
    do_write(32'h40, 4'd0, 3'd2, INCR, 4'd2, 4'd2, 1, 0);
    wd[0] = 32'hDEADBEEF;
    do_write(32'h40, 4'd0, 3'd2, RSVD, 4'd2, 4'd2, 1, 0);
    do_write(32'h40, 4'd0, 3'd2, INCR, 4'd2, 4'd3, 1, 0);
    do_read(32'h40, 4'd0, 3'd2, INCR, 4'd2, -1, 0, -1);
    chk("slverr_no_write", rd_cap[0], 32'hCAFEF00D);
    do_read(32'h40, 4'd1, 3'd3, INCR, 4'd9, -1, 0, -1);
    chk("size_err_data", rd_cap[1], 32'h0);
    do_read(32'h40, 4'd2, 3'd2, WRAP, 4'd9, -1, 0, -1);
    wd[0] = 32'h61; wd[1] = 32'h62; wd[2] = 32'h63; wd[3] = 32'h64;
    do_write(32'h60, 4'd3, 3'd2, INCR, 4'd4, 4'd4, 2, 0);
    do_write(32'h60, 4'd1, 3'd2, INCR, 4'd4, 4'd4, 4, 0);
    do_read(32'h60, 4'd1, 3'd2, INCR, 4'd4, -1, 0, -1);
    wd[0] = 32'h5A5A5A5A;
    do_write(32'h3FC, 4'd0, 3'd2, INCR, 4'd6, 4'd6, 1, 0);
    do_read(32'h3FC, 4'd1, 3'd2, INCR, 4'd6, -1, 0, -1);
    chk("edge_ok_beat", rd_cap[0], 32'h5A5A5A5A);

    // Reset during beat 2 of a 4-beat read
    do_read(32'h10, 4'd3, 3'd2, INCR, 4'd5, -1, 0, 1);
    #2 arstn = 1'b0;
    #1 chk("midburst_reset_outputs",
           {awready, wready, bvalid, bid, bresp, arready, rvalid, rdata, rid, rresp, rlast}, 64'd0);
    bq.delete();
    rq.delete();
    repeat (2) @(posedge aclk);
    #1 arstn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    chk("release_ready", {awready, wready, arready}, 3'b101);
    wd[0] = 32'h77; wd[1] = 32'h78;
    do_write(32'h70, 4'd1, 3'd2, INCR, 4'd10, 4'd10, 2, 0);
    do_read(32'h70, 4'd1, 3'd2, INCR, 4'd11, -1, 0, -1);
    chk("after_reset_beat1", rd_cap[1], 32'h78);

    repeat (3) @(posedge aclk);
    chk("b_queue_drained", 64'(bq.size()), 64'd0);
    chk("r_queue_drained", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
